// File: rtl/mux_scan_sel.sv
// Channel selector: routes one slice of in_bus to a registered output, either
// by manual index or by timed round-robin scan with hold.
module mux_scan_sel #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 1,
  parameter  int DWELL    = 8,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      hold,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [SELW-1:0]           cur_ch,
  output logic                      ch_step,
  output logic                      sel_err
);

  localparam int DCW = $clog2(DWELL + 1);
  localparam logic [DCW-1:0]  DW_LAST = DCW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);
  localparam logic [SELW:0]   CH_MAX  = (SELW + 1)'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [SELW-1:0]   cur_ch_q, cur_ch_d;
  logic              ch_step_q, ch_step_d;
  logic              sel_err_q, sel_err_d;
  logic [DCW-1:0]    dwell_cnt_q, dwell_cnt_d;

  logic [WIDTH-1:0]  sel_data, cur_data;
  logic              sel_oor;

  always_comb begin
    sel_data = '0;
    cur_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel == SELW'(k))      sel_data = in_bus[k*WIDTH +: WIDTH];
      if (cur_ch_q == SELW'(k)) cur_data = in_bus[k*WIDTH +: WIDTH];
    end
    sel_oor = ({1'b0, sel} > CH_MAX);
  end

  // Next state comes from en/mode; the actions below follow the current state.
  always_comb begin
    state_d     = !en ? IDLE : (mode ? SCAN : MANUAL);
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cur_ch_d    = cur_ch_q;
    ch_step_d   = 1'b0;
    sel_err_d   = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    case (state_q)
      IDLE: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        dwell_cnt_d = '0;
      end
      MANUAL: begin
        // Clearing here gives every SCAN entry a full dwell on the kept channel.
        dwell_cnt_d = '0;
        if (sel_oor) begin
          out_d       = '0;
          out_valid_d = 1'b0;
          sel_err_d   = 1'b1;
        end else begin
          cur_ch_d    = sel;
          out_d       = sel_data;
          out_valid_d = 1'b1;
          ch_step_d   = (sel != cur_ch_q);
        end
      end
      SCAN: begin
        out_d       = cur_data;
        out_valid_d = 1'b1;
        if (!hold) begin
          if (dwell_cnt_q == DW_LAST) begin
            dwell_cnt_d = '0;
            cur_ch_d    = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + SELW'(1);
            ch_step_d   = 1'b1;
          end else begin
            dwell_cnt_d = dwell_cnt_q + DCW'(1);
          end
        end
      end
      default: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        dwell_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cur_ch_q    <= '0;
      ch_step_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cur_ch_q    <= cur_ch_d;
      ch_step_q   <= ch_step_d;
      sel_err_q   <= sel_err_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cur_ch    = cur_ch_q;
  assign ch_step   = ch_step_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: a 4-channel DWELL=3 instance and a
// 3-channel DWELL=1 instance, expectations queued per edge and checked after it.
module tb_mux_scan_sel;

  typedef struct packed {
    logic       o;
    logic       v;
    logic [1:0] c;
    logic       s;
    logic       e;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_en = 1'b0, a_mode = 1'b0, a_hold = 1'b0;
  logic [1:0] a_sel = '0;
  logic [3:0] a_in = '0;
  logic [0:0] a_out;
  logic       a_valid, a_step, a_err;
  logic [1:0] a_cur;

  logic       b_en = 1'b0, b_mode = 1'b0, b_hold = 1'b0;
  logic [1:0] b_sel = '0;
  logic [2:0] b_in = '0;
  logic [0:0] b_out;
  logic       b_valid, b_step, b_err;
  logic [1:0] b_cur;

  int tests = 0;
  int fails = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  mux_scan_sel #(.CHANNELS(4), .WIDTH(1), .DWELL(3)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .hold(a_hold), .sel(a_sel),
    .in_bus(a_in), .out(a_out), .out_valid(a_valid), .cur_ch(a_cur),
    .ch_step(a_step), .sel_err(a_err)
  );

  mux_scan_sel #(.CHANNELS(3), .WIDTH(1), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .hold(b_hold), .sel(b_sel),
    .in_bus(b_in), .out(b_out), .out_valid(b_valid), .cur_ch(b_cur),
    .ch_step(b_step), .sel_err(b_err)
  );

  function automatic obs_t x(input logic o, input logic v, input logic [1:0] c,
                             input logic s, input logic e);
    obs_t r;
    r.o = o; r.v = v; r.c = c; r.s = s; r.e = e;
    return r;
  endfunction

  task automatic check(input bit b);
    obs_t  ex, ob;
    string tg;
    ex = exp_q.pop_front();
    tg = tag_q.pop_front();
    ob = b ? x(b_out[0], b_valid, b_cur, b_step, b_err)
           : x(a_out[0], a_valid, a_cur, a_step, a_err);
    tests++;
    assert (ob === ex) else begin
      fails++;
      $error("FAIL %s: observed out/valid/cur/step/err=%b/%b/%0d/%b/%b expected %b/%b/%0d/%b/%b",
             tg, ob.o, ob.v, ob.c, ob.s, ob.e, ex.o, ex.v, ex.c, ex.s, ex.e);
    end
  endtask

  task automatic cyc(input bit b, input logic en, input logic mode, input logic hold,
                     input logic [1:0] sel, input logic [3:0] ib, input string tag,
                     input obs_t ex);
    if (b) begin
      a_en = 1'b0;
      b_en = en; b_mode = mode; b_hold = hold; b_sel = sel; b_in = ib[2:0];
    end else begin
      b_en = 1'b0;
      a_en = en; a_mode = mode; a_hold = hold; a_sel = sel; a_in = ib;
    end
    exp_q.push_back(ex);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    exp_q.push_back(x(0, 0, 0, 0, 0)); tag_q.push_back("reset_a"); check(0);
    exp_q.push_back(x(0, 0, 0, 0, 0)); tag_q.push_back("reset_b"); check(1);
    #1 rst = 1'b0;

    cyc(0, 0, 0, 0, 0, 4'b0000, "idle",       x(0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 1, 4'b1010, "man_entry",  x(0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 1, 4'b1010, "man_sel1",   x(1, 1, 1, 1, 0));
    cyc(0, 1, 0, 0, 0, 4'b1010, "man_sel0",   x(0, 1, 0, 1, 0));
    cyc(0, 1, 0, 0, 0, 4'b1010, "man_steady", x(0, 1, 0, 0, 0));
    cyc(0, 1, 0, 0, 3, 4'b1010, "man_sel3",   x(1, 1, 3, 1, 0));
    cyc(0, 1, 0, 0, 3, 4'b0000, "man_track",  x(0, 1, 3, 0, 0));
    cyc(0, 1, 0, 0, 3, 4'b1000, "man_out1",   x(1, 1, 3, 0, 0));

    // asynchronous reset pulse between edges while out=1
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(x(0, 0, 0, 0, 0)); tag_q.push_back("rst_async"); check(0);
    #1 rst = 1'b0;

    cyc(0, 1, 1, 0, 0, 4'b1010, "scan_entry", x(0, 0, 0, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1010, "scan_d1",    x(0, 1, 0, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1010, "scan_d2",    x(0, 1, 0, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1010, "scan_step1", x(0, 1, 1, 1, 0));
    cyc(0, 1, 1, 0, 0, 4'b1010, "scan_c1a",   x(1, 1, 1, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1010, "scan_c1b",   x(1, 1, 1, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1010, "scan_step2", x(1, 1, 2, 1, 0));
    cyc(0, 1, 1, 0, 0, 4'b1010, "scan_c2a",   x(0, 1, 2, 0, 0));

    cyc(0, 1, 1, 1, 0, 4'b1010, "hold1",      x(0, 1, 2, 0, 0));
    cyc(0, 1, 1, 1, 0, 4'b1010, "hold2",      x(0, 1, 2, 0, 0));
    cyc(0, 1, 1, 1, 0, 4'b0100, "hold3",      x(1, 1, 2, 0, 0));
    cyc(0, 1, 1, 1, 0, 4'b0100, "hold4",      x(1, 1, 2, 0, 0));
    cyc(0, 1, 1, 1, 0, 4'b0100, "hold5",      x(1, 1, 2, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b0100, "unhold1",    x(1, 1, 2, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b0100, "unhold_st3", x(1, 1, 3, 1, 0));

    cyc(0, 1, 1, 0, 0, 4'b1000, "scan_c3a",   x(1, 1, 3, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1000, "scan_c3b",   x(1, 1, 3, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1000, "scan_wrap0", x(1, 1, 0, 1, 0));
    cyc(0, 1, 1, 0, 0, 4'b1000, "scan_c0a",   x(0, 1, 0, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1000, "scan_c0b",   x(0, 1, 0, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b1000, "scan_st1b",  x(0, 1, 1, 1, 0));

    cyc(0, 0, 1, 0, 0, 4'b1000, "en_drop",    x(0, 1, 1, 0, 0));
    cyc(0, 0, 1, 0, 0, 4'b1000, "idle_keep1", x(0, 0, 1, 0, 0));
    cyc(0, 0, 1, 0, 0, 4'b1000, "idle_keep2", x(0, 0, 1, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b0010, "reen_idle",  x(0, 0, 1, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b0010, "reen_d1",    x(1, 1, 1, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b0010, "reen_d2",    x(1, 1, 1, 0, 0));
    cyc(0, 1, 1, 0, 0, 4'b0010, "reen_step",  x(1, 1, 2, 1, 0));

    cyc(1, 1, 0, 0, 2, 4'b0101, "b_entry",    x(0, 0, 0, 0, 0));
    cyc(1, 1, 0, 0, 2, 4'b0101, "b_sel2",     x(1, 1, 2, 1, 0));
    cyc(1, 1, 0, 0, 3, 4'b0101, "b_oor",      x(0, 0, 2, 0, 1));
    cyc(1, 1, 0, 0, 3, 4'b0101, "b_oor2",     x(0, 0, 2, 0, 1));
    cyc(1, 1, 0, 0, 0, 4'b0101, "b_sel0",     x(1, 1, 0, 1, 0));
    cyc(1, 1, 0, 0, 2, 4'b0101, "b_sel2b",    x(1, 1, 2, 1, 0));
    cyc(1, 1, 1, 0, 2, 4'b0001, "b_modechg",  x(0, 1, 2, 0, 0));
    cyc(1, 1, 1, 0, 2, 4'b0001, "b_wrap",     x(0, 1, 0, 1, 0));
    cyc(1, 1, 1, 0, 2, 4'b0001, "b_s1",       x(1, 1, 1, 1, 0));
    cyc(1, 1, 1, 0, 2, 4'b0001, "b_s2",       x(0, 1, 2, 1, 0));
    cyc(1, 1, 1, 0, 2, 4'b0001, "b_s3",       x(0, 1, 0, 1, 0));
    cyc(1, 1, 1, 1, 2, 4'b0001, "b_hold",     x(1, 1, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_sel.md
MUX_SCAN_SEL -- requirements
Module: mux_scan_sel

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 1, bits per channel (1..8).
REQ-003 SHALL have parameter DWELL, default 8, cycles per channel in scan mode (1..255).
REQ-004 SHALL derive SELW = clog2(CHANNELS), minimum 1.
REQ-005 SHALL have port clk, input, 1, the single clock; all flops rising-edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port en, input, 1, block enable.
REQ-008 SHALL have port mode, input, 1, 0 = manual select, 1 = auto-scan.
REQ-009 SHALL have port hold, input, 1, freezes scan progression.
REQ-010 SHALL have port sel, input, SELW, manual channel index.
REQ-011 SHALL have port in_bus, input, CHANNELS*WIDTH, channel k at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port out, output, WIDTH, registered selected data.
REQ-013 SHALL have port out_valid, output, 1, out holds live channel data.
REQ-014 SHALL have port cur_ch, output, SELW, channel currently routed.
REQ-015 SHALL have port ch_step, output, 1, one-cycle pulse when cur_ch changes.
REQ-016 SHALL have port sel_err, output, 1, manual sel out of range (sampled last edge).

Function
REQ-017 SHALL implement FSM states IDLE, MANUAL, SCAN in a state register.
REQ-018 SHALL compute next state each edge: !en -> IDLE; en & !mode -> MANUAL; en & mode -> SCAN. Actions in a cycle follow the current state, so mode/en changes take effect one cycle later.
REQ-019 IDLE: out <= 0, out_valid <= 0, dwell_cnt <= 0, cur_ch held, ch_step <= 0, sel_err <= 0.
REQ-020 MANUAL, sel < CHANNELS: cur_ch <= sel, out <= in_bus slice[sel], out_valid <= 1, sel_err <= 0; latency one edge from sel/in_bus to out.
REQ-021 MANUAL, sel >= CHANNELS (non-power-of-two CHANNELS): out <= 0, out_valid <= 0, sel_err <= 1, cur_ch unchanged.
REQ-022 MANUAL: ch_step <= 1 exactly when the new cur_ch differs from the old cur_ch.
REQ-023 SCAN: out <= in_bus slice[cur_ch] every edge, out_valid <= 1, sel_err <= 0.
REQ-024 SCAN, hold=0: dwell_cnt increments; at dwell_cnt == DWELL-1, dwell_cnt <= 0, cur_ch advances, ch_step <= 1 for one cycle.
REQ-025 cur_ch SHALL wrap from CHANNELS-1 to 0 (no out-of-range value for non-power-of-two CHANNELS).
REQ-026 SCAN, hold=1: dwell_cnt and cur_ch frozen, ch_step <= 0, out keeps tracking in_bus of frozen channel.
REQ-027 Entry to SCAN from any other state SHALL clear dwell_cnt and keep cur_ch.
REQ-028 DWELL=1 SHALL advance cur_ch every edge in SCAN.
REQ-029 dwell_cnt SHALL be clog2(DWELL+1) bits wide; no overflow possible.

Reset
REQ-030 rst=1 SHALL immediately, without clock, force state=IDLE, out=0, out_valid=0, cur_ch=0, dwell_cnt=0, ch_step=0, sel_err=0.
REQ-031 rst asserted mid-scan SHALL abort the scan; after release, the block restarts at channel 0 with dwell_cnt=0.
REQ-032 After rst release, the first edge only updates the state; outputs become valid on the second edge.

Verification (CHANNELS=4, WIDTH=1, DWELL=3 unless stated)
REQ-033 SHALL verify: rst pulse mid-cycle with out=1 -> all outputs 0 immediately, before the next edge.
REQ-034 SHALL verify: en=1, mode=0, in_bus=4'b1010, sel=1 -> one edge after MANUAL entry, out=1, cur_ch=1, ch_step=1; sel=0 next cycle -> out=0, ch_step=1.
REQ-035 SHALL verify: en=1, mode=1 from IDLE -> cur_ch stays 0 for 3 edges, then steps 1,2,3,0 every 3 edges with ch_step one-cycle pulses; out follows in_bus bit of cur_ch.
REQ-036 SHALL verify: SCAN at cur_ch=2 with dwell_cnt=1, hold=1 for 5 cycles -> cur_ch stays 2, no ch_step; after hold=0, step to 3 occurs 2 edges later.
REQ-037 SHALL verify: CHANNELS=3, mode=0, sel=3 -> sel_err=1, out=0, out_valid=0, cur_ch unchanged; in SCAN, wrap 2 -> 0.
REQ-038 SHALL verify: en dropped during SCAN -> IDLE one edge later, out=0, out_valid=0, cur_ch retained; re-enable resumes at the retained channel with a full DWELL.
